// File: rtl/piso_shift_ctrl_pkg.sv
// Shared types and constants for the parallel-in serial-out shifter.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int LSB_FIRST_C = 1;
   localparam int MSB_FIRST_C = 0;

   // Bit-counter width for a given word width (never narrower than one bit).
   function automatic int cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/piso_shift_ctrl_if.sv
// Load handshake and serial output bundle of the PISO shifter.
interface piso_shift_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] din;
   logic             shift_en;
   logic             sout;
   logic             sout_valid;
   logic             frame_start;
   logic             frame_last;
   logic             busy;

   // Producer / serial consumer side.
   modport master (
      output load_valid, din, shift_en,
      input  load_ready, sout, sout_valid, frame_start, frame_last, busy
   );

   // Shifter side.
   modport slave (
      input  load_valid, din, shift_en,
      output load_ready, sout, sout_valid, frame_start, frame_last, busy
   );
endinterface

// File: rtl/piso_shift_ctrl_bit_counter.sv
// Loadable down-counter with enable and zero flag; holds at zero.
module piso_bit_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         zero
);

   // Load has priority over counting; no wrap below zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   cnt <= '0;
      else if (load)             cnt <= load_val;
      else if (en && cnt != '0)  cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/piso_shift_ctrl.sv
// Parallel-in serial-out shifter with valid/ready load, stall and frame markers.
module piso_shift_ctrl
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 1
) (
   input  logic           clk,
   input  logic           rst,
   piso_shift_ctrl_if.slave bus
);

   localparam int            CW  = cnt_w(WIDTH);
   localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);

   state_t           state, nxt;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             zero;
   logic             ready;
   logic             accept;
   logic             adv;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Next state and load_ready; ready never looks at load_valid.
   always_comb begin
      nxt   = state;
      ready = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.load_valid) nxt = SHIFT;
         end
         SHIFT: begin
            if (bus.shift_en && zero) begin
               ready = 1'b1;
               nxt   = bus.load_valid ? SHIFT : IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   assign bus.load_ready = ready && !rst;
   assign accept         = bus.load_valid && bus.load_ready;
   assign adv            = (state == SHIFT) && bus.shift_en;

   // Shift register: a new word wins; the last-bit shift also clears the
   // final bit so sout rests at 0 in IDLE straight from the register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         shreg <= '0;
      else if (accept) shreg <= bus.din;
      else if (adv)    shreg <= (LSB_FIRST == LSB_FIRST_C) ? (shreg >> 1) : (shreg << 1);
   end

   piso_bit_counter #(.W(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .en       (adv),
      .load_val (TOP),
      .cnt      (cnt),
      .zero     (zero)
   );

   assign bus.sout        = (LSB_FIRST == LSB_FIRST_C) ? shreg[0] : shreg[WIDTH-1];
   assign bus.sout_valid  = (state == SHIFT);
   assign bus.busy        = (state == SHIFT);
   assign bus.frame_start = (state == SHIFT) && (cnt == TOP);
   assign bus.frame_last  = (state == SHIFT) && zero;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Self-checking bench: table-driven frames plus hand sequences, serial
// bits checked against a scoreboard of expected (bit, start, last) records.
module tb_piso_shift_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   piso_shift_ctrl_if #(.WIDTH(8)) ifa ();
   piso_shift_ctrl_if #(.WIDTH(8)) ifb ();
   piso_shift_ctrl_if #(.WIDTH(3)) ifc ();

   piso_shift_ctrl #(.WIDTH(8), .LSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   piso_shift_ctrl #(.WIDTH(8), .LSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
   piso_shift_ctrl #(.WIDTH(3), .LSB_FIRST(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

   typedef struct packed {logic b; logic fs; logic fl;} exp_t;

   // din, expected stream for LSB-first and MSB-first (bit 7 leaves first),
   // stall position/length, expected frame length in cycles.
   typedef struct {
      logic [7:0] din;
      logic [7:0] sl;
      logic [7:0] sm;
      int         stall_at;
      int         stall_len;
      int         cycles;
   } vec_t;

   exp_t qa[$], qb[$], qc[$];
   int   errors = 0;
   int   checks = 0;
   vec_t vt[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp(input string nm, input logic v, s, fs, fl, bz, input int n, input exp_t h);
      chk({nm, "_busy"}, bz, v);
      if (v) begin
         if (n == 0) chk({nm, "_extra_bit"}, 0, 1);
         else begin
            chk({nm, "_sout"}, s, h.b);
            chk({nm, "_fstart"}, fs, h.fs);
            chk({nm, "_flast"}, fl, h.fl);
         end
      end else begin
         chk({nm, "_idle_sout"}, s, 0);
         chk({nm, "_idle_fs"}, fs, 0);
         chk({nm, "_idle_fl"}, fl, 0);
      end
   endtask

   // Scoreboard monitor: compare head each valid cycle, consume it when shift_en.
   always @(negedge clk) begin
      if (!rst) begin
         cmp("a", ifa.sout_valid, ifa.sout, ifa.frame_start, ifa.frame_last, ifa.busy,
             qa.size(), (qa.size() != 0) ? qa[0] : exp_t'(0));
         if (ifa.sout_valid && ifa.shift_en && qa.size() != 0) void'(qa.pop_front());
         cmp("b", ifb.sout_valid, ifb.sout, ifb.frame_start, ifb.frame_last, ifb.busy,
             qb.size(), (qb.size() != 0) ? qb[0] : exp_t'(0));
         if (ifb.sout_valid && ifb.shift_en && qb.size() != 0) void'(qb.pop_front());
         cmp("c", ifc.sout_valid, ifc.sout, ifc.frame_start, ifc.frame_last, ifc.busy,
             qc.size(), (qc.size() != 0) ? qc[0] : exp_t'(0));
         if (ifc.sout_valid && ifc.shift_en && qc.size() != 0) void'(qc.pop_front());
      end
   end

   task automatic drive8(input logic lv, input logic [7:0] d, input logic se);
      ifa.load_valid = lv; ifb.load_valid = lv;
      ifa.din        = d;  ifb.din        = d;
      ifa.shift_en   = se; ifb.shift_en   = se;
   endtask

   task automatic push8(input logic [7:0] sl, input logic [7:0] sm);
      for (int i = 0; i < 8; i++) begin
         qa.push_back('{b: sl[7-i], fs: (i == 0), fl: (i == 7)});
         qb.push_back('{b: sm[7-i], fs: (i == 0), fl: (i == 7)});
      end
   endtask

   task automatic push3(input logic [2:0] s);
      for (int i = 0; i < 3; i++) qc.push_back('{b: s[2-i], fs: (i == 0), fl: (i == 2)});
   endtask

   // Offer a word from IDLE (entered at posedge+1), serialise with optional stall.
   task automatic run8(input vec_t v);
      int vc;
      drive8(1'b1, v.din, 1'b1);
      push8(v.sl, v.sm);
      @(negedge clk);
      chk("idle_ready", ifa.load_ready, 1);
      @(posedge clk); #1;
      drive8(1'b0, v.din, 1'b1);
      vc = 0;
      for (int k = 0; k < 8; k++) begin
         for (int s = 0; s < ((k == v.stall_at) ? v.stall_len : 0); s++) begin
            ifa.shift_en = 1'b0; ifb.shift_en = 1'b0;
            @(negedge clk);
            vc += int'(ifa.sout_valid);
            chk("stall_ready", ifa.load_ready, 0);
            @(posedge clk); #1;
         end
         ifa.shift_en = 1'b1; ifb.shift_en = 1'b1;
         @(negedge clk);
         vc += int'(ifa.sout_valid);
         chk("bit_ready", ifa.load_ready, (k == 7));
         @(posedge clk); #1;
      end
      chk("frame_len", vc, v.cycles);
      chk("idle_after_a", ifa.sout_valid, 0);
      chk("idle_after_b", ifb.sout_valid, 0);
   endtask

   task automatic run3(input logic [2:0] d, input logic [2:0] s);
      ifc.load_valid = 1'b1; ifc.din = d; ifc.shift_en = 1'b1;
      push3(s);
      @(negedge clk);
      chk("c_idle_ready", ifc.load_ready, 1);
      @(posedge clk); #1;
      ifc.load_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("c_valid", ifc.sout_valid, 1);
         chk("c_ready", ifc.load_ready, (c == 3));
         @(posedge clk); #1;
      end
      chk("c_idle_after", ifc.sout_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int vc;
      vt[0] = '{8'h1E, 8'b0111_1000, 8'b0001_1110, -1, 0, 8};
      vt[1] = '{8'h01, 8'b1000_0000, 8'b0000_0001, -1, 0, 8};
      vt[2] = '{8'h1E, 8'b0111_1000, 8'b0001_1110,  1, 3, 11};
      vt[3] = '{8'hC3, 8'b1100_0011, 8'b1100_0011,  0, 2, 10};
      vt[4] = '{8'h80, 8'b0000_0001, 8'b1000_0000,  7, 1, 9};

      drive8(1'b0, 8'h00, 1'b0);
      ifc.load_valid = 1'b0; ifc.din = 3'b000; ifc.shift_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_ready", ifa.load_ready, 0);
      chk("rst_valid", ifa.sout_valid, 0);
      chk("rst_sout", ifa.sout, 0);
      chk("rst_fs", ifa.frame_start, 0);
      chk("rst_fl", ifa.frame_last, 0);
      chk("rst_busy", ifa.busy, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("rel_ready", ifa.load_ready, 1);

      for (int i = 0; i < 5; i++) run8(vt[i]);

      // Back-to-back FF then 00 offered continuously.
      drive8(1'b1, 8'hFF, 1'b1);
      push8(8'hFF, 8'hFF);
      @(negedge clk);
      @(posedge clk); #1;
      drive8(1'b1, 8'h00, 1'b1);
      push8(8'h00, 8'h00);
      vc = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         vc += int'(ifa.sout_valid);
         if (c < 8)  chk("b2b_ready_low", ifa.load_ready, 0);
         if (c == 8) begin
            chk("b2b_ready_last", ifa.load_ready, 1);
            chk("b2b_flast", ifa.frame_last, 1);
         end
         if (c == 9) chk("b2b_fstart", ifa.frame_start, 1);
         @(posedge clk); #1;
         if (c == 8) drive8(1'b0, 8'h00, 1'b1);
      end
      chk("b2b_len", vc, 16);
      chk("b2b_idle", ifa.sout_valid, 0);

      // AA offered mid-frame must wait for the last-bit cycle.
      drive8(1'b1, 8'h1E, 1'b1);
      push8(8'b0111_1000, 8'b0001_1110);
      @(negedge clk);
      @(posedge clk); #1;
      drive8(1'b0, 8'h1E, 1'b1);
      @(posedge clk); #1;
      drive8(1'b1, 8'hAA, 1'b1);
      for (int c = 2; c <= 8; c++) begin
         @(negedge clk);
         chk("hs_ready", ifa.load_ready, (c == 8));
         @(posedge clk); #1;
         if (c == 8) begin
            push8(8'b0101_0101, 8'b1010_1010);
            drive8(1'b0, 8'hAA, 1'b1);
         end
      end
      repeat (8) begin @(posedge clk); #1; end
      chk("hs_idle", ifa.sout_valid, 0);

      // Async reset mid-frame on the 8-bit instances.
      drive8(1'b1, 8'h1E, 1'b1);
      push8(8'b0111_1000, 8'b0001_1110);
      @(negedge clk);
      @(posedge clk); #1;
      drive8(1'b0, 8'h1E, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      chk("pre_rst_sout", ifa.sout, 1);
      chk("pre_rst_valid", ifa.sout_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_sout", ifa.sout, 0);
      chk("mid_rst_valid", ifa.sout_valid, 0);
      chk("mid_rst_fs", ifa.frame_start, 0);
      chk("mid_rst_fl", ifa.frame_last, 0);
      chk("mid_rst_busy", ifa.busy, 0);
      chk("mid_rst_b_valid", ifb.sout_valid, 0);
      chk("mid_rst_ready", ifa.load_ready, 0);
      qa.delete(); qb.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run8(vt[0]);

      // Odd width: 3-bit instance, normal frames and a mid-frame reset.
      run3(3'b110, 3'b011);
      ifc.load_valid = 1'b1; ifc.din = 3'b100; ifc.shift_en = 1'b1;
      push3(3'b001);
      @(negedge clk);
      @(posedge clk); #1;
      ifc.load_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("c_pre_rst_sout", ifc.sout, 1);
      chk("c_pre_rst_fl", ifc.frame_last, 1);
      rst = 1'b1;
      #1;
      chk("c_rst_sout", ifc.sout, 0);
      chk("c_rst_valid", ifc.sout_valid, 0);
      chk("c_rst_fl", ifc.frame_last, 0);
      chk("c_rst_busy", ifc.busy, 0);
      qc.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run3(3'b101, 3'b101);
      run3(3'b010, 3'b010);

      @(negedge clk);
      chk("qa_empty", qa.size(), 0);
      chk("qb_empty", qb.size(), 0);
      chk("qc_empty", qc.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/piso_shift_ctrl.md
Name: piso_shift_ctrl

Overview:
Parametrised parallel-in serial-out shift register with a valid/ready load handshake, selectable bit order, a shift-enable stall input and frame markers. It converts a WIDTH-bit word into WIDTH serial bits and can accept the next word gaplessly on the cycle its last bit leaves. It is the generalised successor of the team's fixed 4-bit PISO and sits between parallel data producers and serial links or serial test-pattern outputs.

Parameters:
WIDTH, 8, word width in bits; legal range >= 2.
LSB_FIRST, 1, 1 = shift out bit 0 first; 0 = shift out bit WIDTH-1 first.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
load_valid  input  1  producer offers din
load_ready  output  1  block accepts din this cycle
din  input  WIDTH  parallel word, sampled when load_valid && load_ready
shift_en  input  1  advance the serial stream this cycle; 0 = stall
sout  output  1  current serial bit
sout_valid  output  1  sout carries a frame bit
frame_start  output  1  sout is the first bit of a word
frame_last  output  1  sout is the last bit of a word
busy  output  1  a word is being serialised (equals sout_valid)

Behaviour:
- Reset (async, rst=1): state IDLE, shift register 0, bit counter 0. Outputs: sout=0, sout_valid=0, frame_start=0, frame_last=0, busy=0. load_ready=0 while rst=1 and 1 in IDLE after release.
- States: IDLE and SHIFT, both registered.
- IDLE: load_ready=1. If load_valid=1, at the clock edge: capture din, set counter to WIDTH-1, go to SHIFT.
- SHIFT: sout_valid=1. sout = shreg[0] when LSB_FIRST=1, otherwise shreg[WIDTH-1]. It is driven directly from the register, with no combinational path from din.
  - frame_start=1 while counter == WIDTH-1.
  - frame_last=1 while counter == 0.
- Advancing: with shift_en=1 and counter > 0, at the clock edge the register shifts toward the output end, fills with 0, and the counter decrements.
  - With shift_en=0, the register, counter and all outputs hold (stall of any length).
- Last bit (counter == 0 and shift_en=1):
  - load_ready=1 in that cycle.
  - If load_valid=1, the new din is captured, the counter is reloaded to WIDTH-1 and the state stays SHIFT. This gives a back-to-back frame with no idle cycle.
  - Otherwise go to IDLE.
- load_ready formula: (state==IDLE) || (state==SHIFT && counter==0 && shift_en). This is combinational from state, counter and shift_en only; it never depends on load_valid.
- Latency: a word accepted at edge N puts its first bit on sout from edge N until N+1. Each bit lasts one cycle per shift_en=1 cycle. A word needs exactly WIDTH shift_en-high cycles.
- load_valid with load_ready=0: ignored. The producer must hold din and load_valid until it is accepted.
- Counter width: $clog2(WIDTH). No wrap-around beyond the 0 -> WIDTH-1 reload.
- Reset mid-frame: the frame is abandoned immediately (async) and outputs go to reset values. No partial frame resumes after reset.
- shift_en in IDLE: no effect.

Decomposition:
- Shared package piso_pkg holds:
  - state typedef (IDLE, SHIFT)
  - localparam helper for counter width ($clog2(WIDTH))
  - bit-order constants LSB_FIRST_C=1 and MSB_FIRST_C=0
- One natural sub-module, piso_bit_counter: a loadable down-counter with load, enable and a zero flag. Everything else stays inline.

Test Plan:
- WIDTH=8, LSB_FIRST=1, rst pulse, then din=8'h1E with load_valid=1 and shift_en=1 held -> sout over 8 cycles = 0,1,1,1,1,0,0,0; frame_start only on cycle 1; frame_last only on cycle 8; load_ready=1 on cycle 8; IDLE afterwards with sout_valid=0.
- WIDTH=8, LSB_FIRST=0, din=8'h1E -> sout = 0,0,0,1,1,1,1,0.
- Back-to-back: 8'hFF then 8'h00 offered continuously -> 16 consecutive sout_valid cycles (8 ones, then 8 zeros); frame_last at cycle 8 followed immediately by frame_start at cycle 9.
- Stall: din=8'h1E with LSB_FIRST=1, shift_en=0 for 3 cycles after the 2nd bit -> sout holds 1 for 4 cycles; the total frame takes 11 cycles; the bit sequence is unchanged.
- Handshake: load_valid=1 mid-frame with din=8'hAA -> load_ready=0 and din is not captured until the last-bit cycle.
- Async reset asserted mid-frame, between edges -> sout, sout_valid, frame_start, frame_last and busy go to 0 without waiting for a clk edge. After release, a new load serialises correctly. Repeat with WIDTH=3 to check odd widths.
